pll_phase_ctrl: RTL and testbench

Sequencer for dynamic phase adjustment of the ECP5 EHXPLLL that feeds the I/O, video and GPU clocks. It accepts one phase-shift request at a time: output select, direction and step count. It then drives the PLL PHASESEL/PHASEDIR/PHASESTEP pins with correctly timed pulses and confirms lock before reporting completion. It runs in the always-on 25 MHz input-clock domain, alongside the PLL instance, and is controlled by the I/O controller or by board bring-up logic.

---
 rtl/pll_ctrl_pkg.sv | 24 ++
 rtl/pll_phase_timer.sv | 35 +++
 rtl/pll_phase_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic phase sequencer.
// Holds the sequencer state encoding, the PHASESEL output-select codes and
// the width of the shared duration timer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_LOCKWAIT,
    ST_DONE
  } state_e;

  // PHASESEL encoding of the EHXPLLL outputs
  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

  // Wide enough for every duration, LOCK_TIMEOUT being the largest
  localparam int TMR_W = 16;

endpackage

// File: rtl/pll_phase_timer.sv
// Loadable down-counter with terminal-count flag, shared by all sequencer waits.
// Ports: clock/reset; load_i + load_val_i preset the count; tc_o is high while count==0.
// Loading N-1 on state entry makes tc_o rise in the N-th cycle of that state.
module pll_phase_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer driving EHXPLLL PHASESEL/PHASEDIR/PHASESTEP for one phase-shift request at a time.
// Latency: done at cycle 1+SETUP_CYC+N*(PULSE_CYC+GAP_CYC)+1 with lock present (cycle 1 for N=0).
// Backpressure: req_ready = idle & synchronized lock; req_valid while busy is dropped, never queued.
// Ports: clock, reset (sync, active-high); req_valid/req_ready/req_sel/req_dir/req_steps request;
//   done/err/busy status; pll_locked async LOCK in; phasesel/phasedir/phasestep/phaseloadreg to PLL;
//   phase_op/os/os2/os3 tracked phase, live only when PLL_PHASE_TRACK_EN is defined, else tied 0.
module pll_phase_ctrl #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 4,
  parameter int GAP_CYC      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic       done,
  output logic       err,
  output logic       busy,
  input  logic       pll_locked,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic [7:0] phase_op,
  output logic [7:0] phase_os,
  output logic [7:0] phase_os2,
  output logic [7:0] phase_os3
);

  import pll_ctrl_pkg::*;

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q;
  logic       lock_sync;
  logic [1:0] phasesel_q, phasesel_d;
  logic       phasedir_q, phasedir_d;
  logic [7:0] remaining_q, remaining_d;
  logic       phasestep_q, phasestep_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_tc;

  assign lock_sync = sync2_q;

  pll_phase_timer #(.W(TMR_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    phasesel_d  = phasesel_q;
    phasedir_d  = phasedir_q;
    remaining_d = remaining_q;
    err_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          phasesel_d  = req_sel;
          phasedir_d  = req_dir;
          remaining_d = req_steps;
          if (req_steps == 8'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(SETUP_CYC - 1);
          end
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PULSE_CYC - 1);
        end
      end
      ST_PULSE: begin
        if (tmr_tc) begin
          state_d     = ST_GAP;
          remaining_d = remaining_q - 8'd1;
          tmr_load    = 1'b1;
          tmr_val     = TMR_W'(GAP_CYC - 1);
        end
      end
      ST_GAP: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (remaining_q != 8'd0) begin
            state_d = ST_PULSE;
            tmr_val = TMR_W'(PULSE_CYC - 1);
          end else begin
            state_d = ST_LOCKWAIT;
            tmr_val = TMR_W'(LOCK_TIMEOUT - 1);
          end
        end
      end
      ST_LOCKWAIT: begin
        // Lock wins over a timeout expiring in the same cycle
        if (lock_sync) begin
          state_d = ST_DONE;
        end else if (tmr_tc) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies;
    // sync1_q is the next value of lock_sync.
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    phasestep_d = (state_d != ST_PULSE);
    ready_d     = (state_d == ST_IDLE) && sync1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      phasesel_q  <= 2'b00;
      phasedir_q  <= 1'b1;
      remaining_q <= 8'd0;
      phasestep_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= pll_locked;
      sync2_q     <= sync1_q;
      phasesel_q  <= phasesel_d;
      phasedir_q  <= phasedir_d;
      remaining_q <= remaining_d;
      phasestep_q <= phasestep_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready    = ready_q;
  assign done         = done_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign phasesel     = phasesel_q;
  assign phasedir     = phasedir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = 1'b1;

`ifdef PLL_PHASE_TRACK_EN
  // A step counts only once its low pulse has run to its last cycle,
  // so a pulse cut short by reset never reaches the accumulator.
  logic       step_done;
  logic [7:0] delta;
  logic [7:0] ph_op_q, ph_os_q, ph_os2_q, ph_os3_q;

  assign step_done = (state_q == ST_PULSE) && tmr_tc;
  assign delta     = phasedir_q ? 8'd1 : 8'hFF;

  always_ff @(posedge clock) begin
    if (reset) begin
      ph_op_q  <= 8'd0;
      ph_os_q  <= 8'd0;
      ph_os2_q <= 8'd0;
      ph_os3_q <= 8'd0;
    end else if (step_done) begin
      case (phasesel_q)
        SEL_CLKOS:  ph_os_q  <= ph_os_q  + delta;
        SEL_CLKOS2: ph_os2_q <= ph_os2_q + delta;
        SEL_CLKOS3: ph_os3_q <= ph_os3_q + delta;
        default:    ph_op_q  <= ph_op_q  + delta;
      endcase
    end
  end

  assign phase_op  = ph_op_q;
  assign phase_os  = ph_os_q;
  assign phase_os2 = ph_os2_q;
  assign phase_os3 = ph_os3_q;
`else
  assign phase_op  = 8'd0;
  assign phase_os  = 8'd0;
  assign phase_os2 = 8'd0;
  assign phase_os3 = 8'd0;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: directed requests push expected completions into a
// scoreboard queue; a negedge monitor pops and compares whenever done is seen.
module tb_pll_phase_ctrl;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       done;
  logic       err;
  logic       busy;
  logic       pll_locked;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic [7:0] phase_op, phase_os, phase_os2, phase_os3;

  pll_phase_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .done(done), .err(err), .busy(busy),
    .pll_locked(pll_locked),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg),
    .phase_op(phase_op), .phase_os(phase_os), .phase_os2(phase_os2), .phase_os3(phase_os3)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        err;
    logic [1:0]  sel;
    logic        dir;
    logic [31:0] ph;   // {op, os3, os2, os} expected at done
  } exp_t;

  exp_t       sb[$];
  int         falls[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         low_cnt = 0;
  logic       ps_prev = 1'b1;
  logic [7:0] m_ph[4];
  exp_t       mon_e;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor and phasestep pulse recorder
  always @(negedge clock) begin
    if (!reset && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc - acc_cyc + 1, mon_e.cyc);
        chk("done_err", err, mon_e.err);
        chk("done_phasesel", phasesel, mon_e.sel);
        chk("done_phasedir", phasedir, mon_e.dir);
        chk("phase_os", phase_os, mon_e.ph[7:0]);
        chk("phase_os2", phase_os2, mon_e.ph[15:8]);
        chk("phase_os3", phase_os3, mon_e.ph[23:16]);
        chk("phase_op", phase_op, mon_e.ph[31:24]);
      end
    end
    if (ps_prev === 1'b1 && phasestep === 1'b0) falls.push_back(cyc - acc_cyc + 1);
    if (phasestep === 1'b0) low_cnt++;
    ps_prev = phasestep;
  end

  task automatic issue(input logic [1:0] sel, input logic d, input logic [7:0] n,
                       input int exp_cyc, input logic exp_err, input bit push);
    exp_t e;
    int w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("issue_ready", req_ready, 1'b1);
`ifdef PLL_PHASE_TRACK_EN
    if (push) m_ph[sel] = d ? m_ph[sel] + n : m_ph[sel] - n;
`endif
    e.cyc = exp_cyc;
    e.err = exp_err;
    e.sel = sel;
    e.dir = d;
    e.ph  = {m_ph[3], m_ph[2], m_ph[1], m_ph[0]};
    if (push) sb.push_back(e);
    falls.delete();
    low_cnt   = 0;
    req_sel   = sel;
    req_dir   = d;
    req_steps = n;
    req_valid = 1'b1;
    acc_cyc   = cyc + 1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc - acc_cyc + 1 < k) @(negedge clock);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && w < 3000) begin
      @(negedge clock);
      w++;
    end
    chk("idle_busy", busy, 1'b0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int d0;
    #400_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < 4; i++) m_ph[i] = 8'd0;
    reset = 1'b1; req_valid = 1'b0; req_sel = 2'b00; req_dir = 1'b0;
    req_steps = 8'd0; pll_locked = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_phasesel", phasesel, 2'b00);
    chk("rst_phasedir", phasedir, 1'b1);
    chk("rst_phasestep", phasestep, 1'b1);
    chk("phaseloadreg", phaseloadreg, 1'b1);
    chk("rst_phase_all", {phase_op, phase_os3, phase_os2, phase_os}, 32'd0);
    reset = 1'b0;

    // Basic: CLKOP, delay, 3 steps -> done at cycle 28
    issue(2'b11, 1'b1, 8'd3, 28, 1'b0, 1'b1);
    chk("basic_phasesel_c1", phasesel, 2'b11);
    chk("basic_busy_c1", busy, 1'b1);
    chk("basic_ready_c1", req_ready, 1'b0);
    wait_idle();
    chk("basic_falls", falls.size(), 3);
    if (falls.size() == 3) begin
      chk("basic_fall0", falls[0], 3);
      chk("basic_fall1", falls[1], 11);
      chk("basic_fall2", falls[2], 19);
    end
    chk("basic_low_cycles", low_cnt, 12);

    // Zero steps -> done at cycle 1, no PHASESTEP activity
    issue(2'b01, 1'b1, 8'd0, 1, 1'b0, 1'b1);
    wait_idle();
    chk("zero_falls", falls.size(), 0);
    chk("zero_low_cycles", low_cnt, 0);

    // Back-pressure: no lock in IDLE -> not ready, request ignored
    pll_locked = 1'b0;
    repeat (4) @(negedge clock);
    chk("bp_ready_low", req_ready, 1'b0);
    req_sel = 2'b10; req_dir = 1'b1; req_steps = 8'd1; req_valid = 1'b1;
    repeat (5) @(negedge clock);
    req_valid = 1'b0;
    chk("bp_not_busy", busy, 1'b0);
    pll_locked = 1'b1;
    d0 = n_done;
    issue(2'b10, 1'b1, 8'd1, 12, 1'b0, 1'b1);
    wait_cyc(3);
    chk("busy_ready_low", req_ready, 1'b0);
    req_steps = 8'd5; req_valid = 1'b1;
    repeat (4) @(negedge clock);
    req_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clock);
    chk("one_done", n_done - d0, 1);

    // Lock timeout: lock lost during GAP of a 1-step request
    issue(2'b01, 1'b0, 8'd1, 1035, 1'b1, 1'b1);
    wait_cyc(7);
    pll_locked = 1'b0;
    wait_idle();
    pll_locked = 1'b1;

    // Reset during the 2nd PULSE cycle of step 1
    d0 = n_done;
    issue(2'b00, 1'b1, 8'd2, 0, 1'b0, 1'b0);
    wait_cyc(4);
    chk("mid_pulse_low", phasestep, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_phasestep", phasestep, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_ph[i] = 8'd0;
    repeat (40) @(negedge clock);
    chk("rst_mid_phase_os", phase_os, 8'd0);
    chk("rst_mid_no_done", n_done - d0, 0);

    // Wrap-around of CLKOS: -1 -> 255, then +2 -> 1
    issue(2'b00, 1'b0, 8'd1, 12, 1'b0, 1'b1);
    wait_idle();
    issue(2'b00, 1'b1, 8'd2, 20, 1'b0, 1'b1);
    wait_idle();
`ifdef PLL_PHASE_TRACK_EN
    chk("wrap_phase_os", phase_os, 8'd1);
`else
    chk("untracked_phase_os", phase_os, 8'd0);
`endif

    repeat (5) @(negedge clock);
    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
